// File: rtl/fpm_pkg.sv
// Shared types for the fp32 multiplier issue controller.
//   fp32_t    : raw IEEE-754 single word
//   tag_t     : in-flight tracking entry {valid, requester id}
//   NREQ      : number of requesters sharing the datapath
package fpm_pkg;

    localparam int unsigned NREQ = 2;
    localparam int unsigned FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

    // Round-robin pointer moves to the requester that was not just served.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/fpm_rsp_fifo.sv
// Per-requester response FIFO with a registered head.
//   clk, rst      : clock, asynchronous active-high reset
//   i_push        : write i_push_data this cycle
//   i_push_data   : result word to store
//   i_pop         : consumer takes the head this cycle (ignored when empty)
//   o_full        : DEPTH entries held
//   o_empty       : no entries held
//   o_head        : oldest entry, straight from storage registers
module fpm_rsp_fifo
    import fpm_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  fp32_t i_push_data,
    input  logic  i_pop,
    output logic  o_full,
    output logic  o_empty,
    output fp32_t o_head
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fp32_t            r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    fp32_t            w_mem_nxt [DEPTH];
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so push at full is fine then.
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    // Shift-down storage: entry 0 is always the head.
    always_comb begin
        w_mem_nxt   = r_mem;
        w_count_nxt = r_count;
        if (w_pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
            w_count_nxt = r_count - CNT_W'(1);
        end
        if (w_push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == w_count_nxt) begin
                    w_mem_nxt[i] = i_push_data;
                end
            end
            w_count_nxt = w_count_nxt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            r_mem   <= w_mem_nxt;
        end
    end

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[0];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && o_full && !i_pop));

endmodule

// File: rtl/fpm_issue_ctrl.sv
// Round-robin issue controller sharing one pipelined fp32 multiplier
// between two requesters, with credit-limited issue and per-requester
// response FIFOs.
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid/ready         : operation offered / granted (combinational grant)
//   reqN_a, reqN_b           : operands, sampled only in the grant cycle
//   mul_in_valid, mul_a/b    : issue to datapath (operands 0 when idle)
//   mul_result               : product, STAGES cycles after issue
//   rspN_valid/ready/data    : response FIFO head handshake
module fpm_issue_ctrl
    import fpm_pkg::*;
#(
    parameter int unsigned STAGES  = 5,
    parameter int unsigned CREDITS = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req0_valid,
    input  logic  req1_valid,
    output logic  req0_ready,
    output logic  req1_ready,
    input  fp32_t req0_a,
    input  fp32_t req0_b,
    input  fp32_t req1_a,
    input  fp32_t req1_b,
    output logic  mul_in_valid,
    output fp32_t mul_a,
    output fp32_t mul_b,
    input  fp32_t mul_result,
    output logic  rsp0_valid,
    output logic  rsp1_valid,
    input  logic  rsp0_ready,
    input  logic  rsp1_ready,
    output fp32_t rsp0_data,
    output fp32_t rsp1_data
);

    localparam int unsigned CR_W = $clog2(CREDITS + 1);

    logic [CR_W-1:0] r_credit [NREQ];
    logic            r_rr;
    tag_t            r_tag [STAGES];

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_rsp_valid;
    logic [NREQ-1:0] w_pop;
    logic [NREQ-1:0] w_push;
    logic [NREQ-1:0] w_full;
    logic [NREQ-1:0] w_empty;
    logic            w_any;
    logic            w_gid;
    tag_t            w_last;

    assign w_elig[0] = req0_valid && (r_credit[0] != '0);
    assign w_elig[1] = req1_valid && (r_credit[1] != '0);

    // Arbiter: a lone eligible requester wins; a tie goes to r_rr.
    // Grants are held off while reset is asserted so outputs stay at reset values.
    always_comb begin
        w_any   = !rst && (w_elig != '0);
        w_gid   = 1'b0;
        w_grant = '0;
        if (w_elig[0] && w_elig[1]) begin
            w_gid = r_rr;
        end else if (w_elig[1]) begin
            w_gid = 1'b1;
        end
        if (w_any) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    assign req0_ready   = w_grant[0];
    assign req1_ready   = w_grant[1];
    assign mul_in_valid = w_any;
    assign mul_a        = !w_any ? '0 : (w_gid ? req1_a : req0_a);
    assign mul_b        = !w_any ? '0 : (w_gid ? req1_b : req0_b);

    assign w_pop[0] = w_rsp_valid[0] && rsp0_ready;
    assign w_pop[1] = w_rsp_valid[1] && rsp1_ready;

    // Credits: one per outstanding op (in flight or waiting in the FIFO).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                r_credit[i] <= CR_W'(CREDITS);
            end
        end else begin
            if (w_any) begin
                r_rr <= other_req(w_gid);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - CR_W'(1);
                    2'b01:   r_credit[i] <= r_credit[i] + CR_W'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end

    // Tag pipe mirrors the datapath depth; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= tag_t'{v: w_any, id: w_gid};
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_last    = r_tag[STAGES-1];
    assign w_push[0] = w_last.v && (w_last.id == 1'b0);
    assign w_push[1] = w_last.v && (w_last.id == 1'b1);

    fpm_rsp_fifo #(
        .DEPTH       (CREDITS)
    ) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push[0]),
        .i_push_data (mul_result),
        .i_pop       (w_pop[0]),
        .o_full      (w_full[0]),
        .o_empty     (w_empty[0]),
        .o_head      (rsp0_data)
    );

    fpm_rsp_fifo #(
        .DEPTH       (CREDITS)
    ) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push[1]),
        .i_push_data (mul_result),
        .i_pop       (w_pop[1]),
        .o_full      (w_full[1]),
        .o_empty     (w_empty[1]),
        .o_head      (rsp1_data)
    );

    assign w_rsp_valid = ~w_empty;
    assign rsp0_valid  = w_rsp_valid[0];
    assign rsp1_valid  = w_rsp_valid[1];

    for (genvar g = 0; g < NREQ; g++) begin : g_chk
        a_credit_max: assert property (@(posedge clk) disable iff (rst)
            r_credit[g] <= CR_W'(CREDITS));
        a_credit_min: assert property (@(posedge clk) disable iff (rst)
            !(w_grant[g] && !w_pop[g] && (r_credit[g] == '0)));
        a_wb_room: assert property (@(posedge clk) disable iff (rst)
            !(w_push[g] && w_full[g] && !w_pop[g]));
    end

endmodule

// File: tb/tb_fpm_issue_ctrl.sv
module tb_fpm_issue_ctrl;

    localparam int STAGES  = 5;
    localparam int CREDITS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        mul_in_valid;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_data, rsp1_data;

    logic        f_push = 1'b0, f_pop = 1'b0;
    logic [31:0] f_data = '0;
    logic        f_full, f_empty;
    logic [31:0] f_head;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpm_issue_ctrl #(.STAGES(STAGES), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_data(rsp0_data), .rsp1_data(rsp1_data)
    );

    fpm_rsp_fifo #(.DEPTH(2)) u_fifo_chk (
        .clk(clk), .rst(rst), .i_push(f_push), .i_push_data(f_data),
        .i_pop(f_pop), .o_full(f_full), .o_empty(f_empty), .o_head(f_head)
    );

    // Stub datapath: normal-range fp32 multiply (truncating), STAGES deep.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) return {s, 8'(e + 10'd1), p[46:24]};
        return {s, e[7:0], p[45:23]};
    endfunction

    logic [31:0] stub_pipe [STAGES];
    always @(posedge clk) begin
        stub_pipe[0] <= fp_mul(mul_a, mul_b);
        for (int i = 1; i < STAGES; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
    assign mul_result = stub_pipe[STAGES-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        f_push = 1'b0; f_pop = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, mul_in_valid, rsp0_valid, rsp1_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000",
                     {req0_ready, req1_ready, mul_in_valid, rsp0_valid, rsp1_valid});
        end
        n_cmp++;
        if ({mul_a, mul_b, rsp0_data, rsp1_data} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_data got %h %h %h %h want all 0", mul_a, mul_b, rsp0_data, rsp1_data);
        end
        n_cmp++;
        if ({dut.r_credit[0], dut.r_credit[1], dut.r_rr} !== {2'd2, 2'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state got cr0=%0d cr1=%0d rr=%0d want 2 2 0",
                     dut.r_credit[0], dut.r_credit[1], dut.r_rr);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40000000;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, mul_in_valid} !== 3'b101) begin
            n_bad++;
            $display("FAIL single_grant got %b want 101", {req0_ready, req1_ready, mul_in_valid});
        end
        n_cmp++;
        if ({mul_a, mul_b} !== 64'h3FC00000_40000000) begin
            n_bad++;
            $display("FAIL single_operands got %h %h want 3fc00000 40000000", mul_a, mul_b);
        end
        step();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if (dut.r_credit[0] !== 2'd1) begin
            n_bad++;
            $display("FAIL single_credit_taken got %0d want 1", dut.r_credit[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_cmp++;
            if (rsp0_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL single_early_rsp t+%0d got %b want 0", k, rsp0_valid);
            end
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        n_cmp++;
        if ({rsp0_valid, rsp0_data} !== {1'b1, 32'h40400000}) begin
            n_bad++;
            $display("FAIL single_rsp got v=%b d=%h want v=1 d=40400000", rsp0_valid, rsp0_data);
        end
        step();
        rsp0_ready = 1'b0;
        #1;
        n_cmp++;
        if ({rsp0_valid, dut.r_credit[0]} !== {1'b0, 2'd2}) begin
            n_bad++;
            $display("FAIL single_after_pop got v=%b cr=%0d want v=0 cr=2", rsp0_valid, dut.r_credit[0]);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g [12];
        logic [31:0] q0 [$];
        logic [31:0] q1 [$];
        logic [31:0] want;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00,
                  2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_a = 32'h3F800000; req1_a = 32'h3F800000;
        for (int c = 0; c < 32; c++) begin
            req0_valid = (c < 24); req1_valid = (c < 24);
            req0_b = 32'h40000000 + (32'(c) << 8);
            req1_b = 32'h40800000 + (32'(c) << 8);
            #1;
            if (c < 12) begin
                n_cmp++;
                if ({req1_ready, req0_ready} !== exp_g[c]) begin
                    n_bad++;
                    $display("FAIL contention_grant c%0d got %b want %b", c, {req1_ready, req0_ready}, exp_g[c]);
                end
            end
            if (req0_ready) q0.push_back(req0_b);
            if (req1_ready) q1.push_back(req1_b);
            if (rsp0_valid) begin
                want = (q0.size() > 0) ? q0.pop_front() : 32'hDEADBEEF;
                n_cmp++;
                if (rsp0_data !== want) begin
                    n_bad++;
                    $display("FAIL contention_rsp0 c%0d got %h want %h", c, rsp0_data, want);
                end
            end
            if (rsp1_valid) begin
                want = (q1.size() > 0) ? q1.pop_front() : 32'hDEADBEEF;
                n_cmp++;
                if (rsp1_data !== want) begin
                    n_bad++;
                    $display("FAIL contention_rsp1 c%0d got %h want %h", c, rsp1_data, want);
                end
            end
            step();
        end
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++;
            $display("FAIL contention_drain got %0d %0d outstanding want 0 0", q0.size(), q1.size());
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'h3F800000;
        for (int c = 0; c < 10; c++) begin
            req0_b = (c == 0) ? 32'h40100000 : (c == 1) ? 32'h40200000 : 32'h40700000;
            #1;
            n_cmp++;
            if (req0_ready !== (c < 2)) begin
                n_bad++;
                $display("FAIL credit_grant c%0d got %b want %b", c, req0_ready, (c < 2));
            end
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, rsp0_valid, rsp0_data} !== {1'b0, 1'b1, 32'h40100000}) begin
            n_bad++;
            $display("FAIL credit_full_head got rdy=%b v=%b d=%h want 0 1 40100000", req0_ready, rsp0_valid, rsp0_data);
        end
        step();
        rsp0_ready = 1'b0; req0_b = 32'h40300000;
        #1;
        n_cmp++;
        if ({req0_ready, rsp0_data} !== {1'b1, 32'h40200000}) begin
            n_bad++;
            $display("FAIL credit_regrant got rdy=%b d=%h want 1 40200000", req0_ready, rsp0_data);
        end
        step();
        rsp0_ready = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL credit_one_per_pop got %b want 0", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        #1;
        n_cmp++;
        if ({rsp0_valid, rsp0_data} !== {1'b1, 32'h40300000}) begin
            n_bad++;
            $display("FAIL credit_late_rsp got v=%b d=%h want 1 40300000", rsp0_valid, rsp0_data);
        end
        step();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        f_push = 1'b1; f_data = 32'h11111111;
        #1;
        n_cmp++;
        if (f_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_push_latency got empty=%b want 1", f_empty);
        end
        step();
        f_data = 32'h22222222;
        #1;
        n_cmp++;
        if ({f_empty, f_full, f_head} !== {2'b00, 32'h11111111}) begin
            n_bad++;
            $display("FAIL fifo_one got e=%b f=%b h=%h want 0 0 11111111", f_empty, f_full, f_head);
        end
        step();
        f_data = 32'h33333333; f_pop = 1'b1;
        #1;
        n_cmp++;
        if ({f_full, f_head} !== {1'b1, 32'h11111111}) begin
            n_bad++;
            $display("FAIL fifo_full got f=%b h=%h want 1 11111111", f_full, f_head);
        end
        step();
        f_push = 1'b0;
        #1;
        n_cmp++;
        if ({f_full, f_head} !== {1'b1, 32'h22222222}) begin
            n_bad++;
            $display("FAIL fifo_full_pushpop got f=%b h=%h want 1 22222222", f_full, f_head);
        end
        step();
        #1;
        n_cmp++;
        if ({f_empty, f_full, f_head} !== {2'b00, 32'h33333333}) begin
            n_bad++;
            $display("FAIL fifo_order got e=%b f=%b h=%h want 0 0 33333333", f_empty, f_full, f_head);
        end
        step();
        f_pop = 1'b0;
        #1;
        n_cmp++;
        if (f_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_drained got empty=%b want 1", f_empty);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h3F800000; req0_b = 32'h40000000;
        req1_a = 32'h3F800000; req1_b = 32'h40800000;
        step(); step(); step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step(); step();
        #1;
        n_cmp++;
        if (rsp0_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midflight_pre_rsp got %b want 1", rsp0_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, mul_in_valid, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data} !== 69'd0) begin
            n_bad++;
            $display("FAIL midflight_reset_out got %b %h %h want 0",
                     {req0_ready, req1_ready, mul_in_valid, rsp0_valid, rsp1_valid}, rsp0_data, rsp1_data);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < STAGES + 2; k++) begin
            #1;
            n_cmp++;
            if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
                n_bad++;
                $display("FAIL midflight_spurious k%0d got %b want 00", k, {rsp0_valid, rsp1_valid});
            end
            step();
        end
        n_cmp++;
        if ({dut.r_credit[0], dut.r_credit[1]} !== {2'd2, 2'd2}) begin
            n_bad++;
            $display("FAIL midflight_credits got %0d %0d want 2 2", dut.r_credit[0], dut.r_credit[1]);
        end
    endtask

    task automatic test_idle_requester();
        logic exp_r;
        do_reset();
        rsp1_ready = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req1_a = (c == 0) ? 32'h40400000 : (c == 1) ? 32'hC0000000 : 32'h3F800000;
            req1_b = (c < 2) ? 32'h40400000 : 32'h40A00000;
            exp_r = (c < 2) || (c == 7) || (c == 8);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, dut.r_rr} !== {1'b0, exp_r, 1'b0}) begin
                n_bad++;
                $display("FAIL idle_grant c%0d got r0=%b r1=%b rr=%b want 0 %b 0", c, req0_ready, req1_ready, dut.r_rr, exp_r);
            end
            if (!exp_r) begin
                n_cmp++;
                if ({mul_in_valid, mul_a, mul_b} !== 65'd0) begin
                    n_bad++;
                    $display("FAIL idle_mul_zero c%0d got v=%b a=%h b=%h want 0", c, mul_in_valid, mul_a, mul_b);
                end
            end
            if (c == 6 || c == 7) begin
                n_cmp++;
                if ({rsp1_valid, rsp1_data} !== {1'b1, (c == 6) ? 32'h41100000 : 32'hC0C00000}) begin
                    n_bad++;
                    $display("FAIL idle_rsp c%0d got v=%b d=%h want 1 %h", c, rsp1_valid, rsp1_data,
                             (c == 6) ? 32'h41100000 : 32'hC0C00000);
                end
            end
            step();
        end
        req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        step();
        req0_valid = 1'b0;
        step(); step();
        #1;
        n_cmp++;
        if (dut.r_rr !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_rr_after_grant got %b want 1", dut.r_rr);
        end
        rsp1_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_credit_exhaustion();
        test_full_push_pop();
        test_reset_midflight();
        test_idle_requester();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
